bullet_slot_arbiter: RTL
========================

// Module: bullet_slot_arbiter
// PURPOSE
//  Shares the fixed pool of on-screen bullet slots between the player gun and the boss emitters.
//  Grants one free slot per cycle, using round-robin arbitration across requesters.
//  Releases a slot when the renderer retires the bullet.
//  Obeys the game FSM: game_en gates grants, game_reset empties the pool,
//  and the bomb pulse (clear_all) wipes the pool and then holds off new grants.
// PARAMETERS
//  NUM_REQ      4         number of requesters (bit 0 = player, 1..3 = boss emitters)
//  NUM_SLOT     16        bullet slots in the pool
//  SLOT_W       4         slot index width, equals clog2(NUM_SLOT)
//  CLEAR_CYCLES 4000_0000 grant hold-off after clear_all (0.4 s at 100 MHz, matches bomb window)
// PORTS
//  clk         in   1        system clock
//  hard_reset  in   1        async active-high reset
//  game_en     in   1        level from game FSM; 0 = no grants
//  game_reset  in   1        1-cycle sync pulse; empties the pool and returns to OFF
//  clear_all   in   1        1-cycle pulse on bomb entry
//  req         in   NUM_REQ  level requests; held until granted
//  free_valid  in   1        retire strobe from renderer
//  free_slot   in   SLOT_W   slot to retire
//  gnt         out  NUM_REQ  one-hot grant, 1-cycle pulse, registered
//  gnt_valid   out  1        equals |gnt
//  gnt_slot    out  SLOT_W   slot granted; valid only when gnt_valid
//  slot_busy   out  NUM_SLOT occupancy bitmap, registered
//  busy_count  out  SLOT_W+1 popcount of slot_busy, registered, same cycle as slot_busy
//  full        out  1        busy_count == NUM_SLOT
// BEHAVIOUR
//  Reset (hard_reset) values:
//   - gnt, gnt_valid, gnt_slot, slot_busy and busy_count all 0; full 0.
//   - RR pointer 0; hold counter 0; state OFF.
//  States:
//   - OFF:  entered on reset or game_reset; moves to RUN when game_en=1 and game_reset=0.
//   - RUN:  grants enabled.
//   - HOLD: entered from RUN on clear_all; counter loads CLEAR_CYCLES-1 and decrements;
//           at 0 it goes to RUN.
//   - game_en=0 in RUN or HOLD forces OFF.
//  Priority per edge: hard_reset > game_reset > clear_all > free/alloc.
//   - game_reset: slot_busy=0, pointer=0, gnt=0, state OFF; clear_all and free that cycle are ignored.
//   - clear_all: slot_busy=0, no grant that cycle, free ignored.
//     In RUN it enters HOLD; in HOLD it reloads the counter; in OFF it clears only.
//  Allocation (RUN only, not full, some req set):
//   - Winner is the first set req at or after the pointer, scanning upward with wrap.
//   - Slot is the lowest-index 0 bit in the current slot_busy.
//   - Latency: req seen at edge N gives gnt/gnt_slot high for cycle N+1,
//     and the slot_busy bit is set at edge N.
//   - Pointer moves to winner+1 mod NUM_REQ. With no grant the pointer is unchanged.
//   - A granted requester that still holds req in cycle N+1 is re-arbitrated normally.
//     Requesters must drop req on gnt.
//  Free:
//   - Clears slot_busy[free_slot] at the next edge, in any state.
//   - A free of an already-free slot, or free_slot >= NUM_SLOT, is ignored (no count change).
//  Simultaneous alloc + free: both apply on the same edge.
//   - A slot freed this cycle is not allocatable until the next cycle (allocation uses the pre-edge bitmap).
//   - busy_count is unchanged (+1-1).
//  Full: no grant, req pending; the grant is issued the cycle after a free lands.
//  busy_count is never below 0 or above NUM_SLOT. It is updated with the bitmap, not separately derived.
// STRUCTURE
//  stg_defs.vh (shared include) holds:
//   - state encodings ARB_OFF / ARB_RUN / ARB_HOLD;
//   - the requester index defines (REQ_PLAYER = 0);
//   - the CLEAR_CYCLES default, shared with the game FSM bomb timeout.
//  One sub-module, bullet_rr_pick: combinational round-robin picker.
//   - Inputs: req, ptr. Outputs: one-hot winner and its index.
//  Slot priority encoder, bitmap, counter and FSM stay in this module.
// TESTING
//  1. Reset, game_en=1, req=4'b0001 one cycle
//     -> gnt=0001, gnt_slot=0 next cycle; busy_count=1; slot_busy=16'h0001.
//  2. req=4'b1111 held, requesters drop req on grant
//     -> grant order 0,1,2,3; slots 0,1,2,3; pointer back to 0.
//  3. Fill 16 slots, then req=0010
//     -> no grant while full=1; free_slot=5 -> gnt=0010, gnt_slot=5 the cycle after the free lands.
//  4. Full pool, same-cycle free_slot=7 and req -> no grant that cycle; grant slot 7 next cycle.
//  5. 10 slots busy, clear_all in RUN -> slot_busy=0, no gnt for CLEAR_CYCLES cycles, then grants resume;
//     with CLEAR_CYCLES=8, a second clear_all at hold cycle 5 extends the hold to 8 cycles from that point.
//  6. game_reset coincident with req, free and clear_all
//     -> pool empty, gnt=0, state OFF; game_en=0 blocks grants; free of an empty slot leaves busy_count=0.

Source files
------------

// File: rtl/bullet_slot_arbiter_pkg.sv
// Shared definitions for the bullet slot arbiter.
// Contents:
//   - FSM state encodings ARB_OFF / ARB_RUN / ARB_HOLD
//   - Requester index names (player is requester 0; boss emitters follow)
//   - Default clear hold-off length, shared with the game FSM bomb timeout
package bullet_slot_arbiter_pkg;

  localparam logic [1:0] ARB_OFF  = 2'd0;
  localparam logic [1:0] ARB_RUN  = 2'd1;
  localparam logic [1:0] ARB_HOLD = 2'd2;

  localparam int REQ_PLAYER = 0;

  // 0.4 s at 100 MHz, the length of the bomb window
  localparam int CLEAR_CYCLES_DEF = 40_000_000;

endpackage

// File: rtl/bullet_slot_arbiter_if.sv
// Bus between the game side (gun, emitters, renderer, game FSM) and the
// bullet slot arbiter.
// Signals:
//   game_en, game_reset, clear_all  game FSM controls
//   req                             level requests, one bit per requester
//   free_valid, free_slot           retire strobe and slot from the renderer
//   gnt, gnt_valid, gnt_slot        registered one-hot grant pulse and slot
//   slot_busy, busy_count, full     pool occupancy
// Modports: master = game side, slave = arbiter.
interface bullet_slot_arbiter_if #(
  parameter int NUM_REQ  = 4,
  parameter int NUM_SLOT = 16,
  parameter int SLOT_W   = 4
);
  logic                game_en;
  logic                game_reset;
  logic                clear_all;
  logic [NUM_REQ-1:0]  req;
  logic                free_valid;
  logic [SLOT_W-1:0]   free_slot;
  logic [NUM_REQ-1:0]  gnt;
  logic                gnt_valid;
  logic [SLOT_W-1:0]   gnt_slot;
  logic [NUM_SLOT-1:0] slot_busy;
  logic [SLOT_W:0]     busy_count;
  logic                full;

  modport master (
    output game_en, game_reset, clear_all, req, free_valid, free_slot,
    input  gnt, gnt_valid, gnt_slot, slot_busy, busy_count, full
  );

  modport slave (
    input  game_en, game_reset, clear_all, req, free_valid, free_slot,
    output gnt, gnt_valid, gnt_slot, slot_busy, busy_count, full
  );
endinterface

// File: rtl/bullet_rr_pick.sv
// Combinational round-robin picker.
// Ports:
//   req      in   NUM_REQ  pending requests
//   ptr      in   REQ_W    first index to consider
//   win      out  NUM_REQ  one-hot winner (0 when no request)
//   win_idx  out  REQ_W    index of the winner
//   hit      out  1        some request was found
module bullet_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int REQ_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [REQ_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] win,
  output logic [REQ_W-1:0]   win_idx,
  output logic               hit
);
  logic [REQ_W-1:0] idx;

  // Scan upward from ptr with wrap; first set request wins.
  always_comb begin
    win     = '0;
    win_idx = '0;
    hit     = 1'b0;
    idx     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = REQ_W'((int'(ptr) + i) % NUM_REQ);
      if (!hit && req[idx]) begin
        hit      = 1'b1;
        win[idx] = 1'b1;
        win_idx  = idx;
      end
    end
  end
endmodule

// File: rtl/bullet_slot_arbiter.sv
// Bullet slot arbiter: hands out free on-screen bullet slots to the player
// gun and boss emitters, one grant per cycle, round-robin across requesters.
// The renderer retires slots; the game FSM gates, resets and bomb-clears the pool.
// Ports:
//   clk         system clock
//   hard_reset  async active-high reset
//   bus         slave side of bullet_slot_arbiter_if (controls, requests,
//               retire strobe in; grant, occupancy out)
module bullet_slot_arbiter
  import bullet_slot_arbiter_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int NUM_SLOT     = 16,
  parameter int SLOT_W       = 4,
  parameter int CLEAR_CYCLES = CLEAR_CYCLES_DEF
) (
  input logic                  clk,
  input logic                  hard_reset,
  bullet_slot_arbiter_if.slave bus
);
  localparam int REQ_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(CLEAR_CYCLES + 1);
  localparam logic [CNT_W-1:0]  HOLD_LOAD = CNT_W'(CLEAR_CYCLES - 1);
  localparam logic [SLOT_W:0]   COUNT_MAX = (SLOT_W+1)'(NUM_SLOT);

  logic [1:0]          state;
  logic [REQ_W-1:0]    ptr;
  logic [CNT_W-1:0]    hold_cnt;
  logic [NUM_SLOT-1:0] slot_busy;
  logic [SLOT_W:0]     busy_count;
  logic [NUM_REQ-1:0]  gnt;
  logic [SLOT_W-1:0]   gnt_slot;

  logic [NUM_REQ-1:0]  win;
  logic [REQ_W-1:0]    win_idx;
  logic                win_hit;
  logic [SLOT_W-1:0]   alloc_slot;
  logic                slot_hit;
  logic                full;
  logic                alloc;
  logic                free_hit;
  logic [NUM_SLOT-1:0] alloc_mask;
  logic [NUM_SLOT-1:0] free_mask;

  bullet_rr_pick #(.NUM_REQ(NUM_REQ), .REQ_W(REQ_W)) u_pick (
    .req     (bus.req),
    .ptr     (ptr),
    .win     (win),
    .win_idx (win_idx),
    .hit     (win_hit)
  );

  // Lowest-index free slot; descending scan so the last assignment wins.
  always_comb begin
    alloc_slot = '0;
    slot_hit   = 1'b0;
    for (int s = NUM_SLOT - 1; s >= 0; s--) begin
      if (!slot_busy[s]) begin
        slot_hit   = 1'b1;
        alloc_slot = SLOT_W'(s);
      end
    end
  end

  assign full = (busy_count == COUNT_MAX);

  // Grant only from RUN with the gate open; game_reset/clear_all suppress it
  // in the sequential block. Allocation sees the pre-edge bitmap, so a slot
  // freed this cycle cannot be handed out until the next one.
  assign alloc = (state == ARB_RUN) && bus.game_en && !full && win_hit && slot_hit;

  // Retiring a slot that is already free (or out of range) is a no-op.
  assign free_hit = bus.free_valid && (int'(bus.free_slot) < NUM_SLOT) &&
                    slot_busy[bus.free_slot];

  always_comb begin
    alloc_mask = '0;
    free_mask  = '0;
    if (alloc)    alloc_mask[alloc_slot]   = 1'b1;
    if (free_hit) free_mask[bus.free_slot] = 1'b1;
  end

  // Pool, grant and pointer.
  always_ff @(posedge clk or posedge hard_reset) begin
    if (hard_reset) begin
      slot_busy  <= '0;
      busy_count <= '0;
      gnt        <= '0;
      gnt_slot   <= '0;
      ptr        <= '0;
    end else if (bus.game_reset) begin
      slot_busy  <= '0;
      busy_count <= '0;
      gnt        <= '0;
      gnt_slot   <= '0;
      ptr        <= '0;
    end else begin
      gnt      <= '0;
      gnt_slot <= '0;
      if (bus.clear_all) begin
        slot_busy  <= '0;
        busy_count <= '0;
      end else begin
        slot_busy  <= (slot_busy & ~free_mask) | alloc_mask;
        busy_count <= busy_count + (SLOT_W+1)'(alloc) - (SLOT_W+1)'(free_hit);
        if (alloc) begin
          gnt      <= win;
          gnt_slot <= alloc_slot;
          ptr      <= REQ_W'((int'(win_idx) + 1) % NUM_REQ);
        end
      end
    end
  end

  // Game-state FSM. game_en low always wins over RUN/HOLD transitions.
  always_ff @(posedge clk or posedge hard_reset) begin
    if (hard_reset) begin
      state    <= ARB_OFF;
      hold_cnt <= '0;
    end else if (bus.game_reset || !bus.game_en) begin
      state    <= ARB_OFF;
      hold_cnt <= '0;
    end else begin
      case (state)
        ARB_OFF: state <= ARB_RUN;
        ARB_RUN: begin
          if (bus.clear_all) begin
            state    <= ARB_HOLD;
            hold_cnt <= HOLD_LOAD;
          end
        end
        ARB_HOLD: begin
          if (bus.clear_all)      hold_cnt <= HOLD_LOAD;
          else if (hold_cnt == 0) state    <= ARB_RUN;
          else                    hold_cnt <= hold_cnt - 1'b1;
        end
        default: state <= ARB_OFF;
      endcase
    end
  end

  assign bus.gnt        = gnt;
  assign bus.gnt_valid  = |gnt;
  assign bus.gnt_slot   = gnt_slot;
  assign bus.slot_busy  = slot_busy;
  assign bus.busy_count = busy_count;
  assign bus.full       = full;
endmodule
